// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state codes, default periods and period helper for the pong game
package pong_pkg;

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] SAQUE   = 3'd1;
  localparam logic [2:0] JOGANDO = 3'd2;
  localparam logic [2:0] PAUSA   = 3'd3;
  localparam logic [2:0] PERDEU  = 3'd4;
  localparam logic [2:0] GANHOU  = 3'd5;

  typedef enum logic [2:0] {
    ST_OCIOSO  = OCIOSO,
    ST_SAQUE   = SAQUE,
    ST_JOGANDO = JOGANDO,
    ST_PAUSA   = PAUSA,
    ST_PERDEU  = PERDEU,
    ST_GANHOU  = GANHOU
  } estado_t;

  localparam int unsigned DIV_BASE_PADRAO     = 25_000_000;
  localparam int unsigned DIV_PASSO_PADRAO    = 2_500_000;
  localparam int unsigned DIV_MIN_PADRAO      = 5_000_000;
  localparam int unsigned SAQUE_CICLOS_PADRAO = 50_000_000;

  // Move period for a given score, clamped to the floor without unsigned wrap.
  function automatic logic [31:0] calc_periodo(input logic [2:0]  pontos,
                                               input logic [31:0] base,
                                               input logic [31:0] passo,
                                               input logic [31:0] minimo);
    logic [31:0] reducao;
    reducao = 32'(pontos) * passo;
    if (reducao >= base) begin
      return minimo;
    end else if ((base - reducao) < minimo) begin
      return minimo;
    end else begin
      return base - reducao;
    end
  endfunction

endpackage

// File: rtl/controle_jogo_if.sv
// rtl/controle_jogo_if.sv - link between the game sequencer and the ball datapath
interface controle_jogo_if;
  logic       perdeu;
  logic       ganhou;
  logic [2:0] pontos;
  logic       atualiza_posicao;
  logic       reset_bola;

  modport master (
    input  perdeu,
    input  ganhou,
    input  pontos,
    output atualiza_posicao,
    output reset_bola
  );

  modport slave (
    output perdeu,
    output ganhou,
    output pontos,
    input  atualiza_posicao,
    input  reset_bola
  );
endinterface

// File: rtl/detector_borda.sv
// rtl/detector_borda.sv - rising-edge detector for a debounced button level
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic nivel,
  output logic pulso
);

  logic anterior_q;
  logic anterior_d;

  // Next sample is simply the current level.
  always_comb begin
    anterior_d = nivel;
  end

  // Reset preloads "pressed" so a button held through reset cannot fire until released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      anterior_q <= 1'b1;
    end else begin
      anterior_q <= anterior_d;
    end
  end

  assign pulso = nivel & ~anterior_q;

endmodule

// File: rtl/controle_jogo.sv
// rtl/controle_jogo.sv - game sequencer: serve delay, score-paced move pulses, win/loss/pause (PAUSA_EN)
module controle_jogo
  import pong_pkg::*;
#(
  parameter int unsigned DIV_BASE     = DIV_BASE_PADRAO,
  parameter int unsigned DIV_PASSO    = DIV_PASSO_PADRAO,
  parameter int unsigned DIV_MIN      = DIV_MIN_PADRAO,
  parameter int unsigned SAQUE_CICLOS = SAQUE_CICLOS_PADRAO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              botao_iniciar,
  input  logic              botao_pausa,
  controle_jogo_if.master   bola,
  output logic [2:0]        estado,
  output logic              led_perdeu,
  output logic              led_ganhou
);

  localparam logic [31:0] BASE_W    = 32'(DIV_BASE);
  localparam logic [31:0] PASSO_W   = 32'(DIV_PASSO);
  localparam logic [31:0] MIN_W     = 32'(DIV_MIN);
  localparam logic [31:0] SAQUE_MAX = 32'(SAQUE_CICLOS - 1);

  estado_t     est_q, est_d;
  logic [31:0] saque_cnt_q, saque_cnt_d;
  logic [31:0] mov_cnt_q, mov_cnt_d;
  logic        pulso_q, pulso_d;
  logic        reset_bola_q, reset_bola_d;
  logic        led_perdeu_q, led_perdeu_d;
  logic        led_ganhou_q, led_ganhou_d;

  logic        evento_iniciar;
  logic        evento_pausa;
  logic [31:0] periodo;

  detector_borda u_borda_iniciar (
    .clk   (clk),
    .reset (reset),
    .nivel (botao_iniciar),
    .pulso (evento_iniciar)
  );

`ifdef PAUSA_EN
  detector_borda u_borda_pausa (
    .clk   (clk),
    .reset (reset),
    .nivel (botao_pausa),
    .pulso (evento_pausa)
  );
`else
  logic unused_pausa;
  assign unused_pausa = botao_pausa;
  assign evento_pausa = 1'b0;
`endif

  assign periodo = calc_periodo(bola.pontos, BASE_W, PASSO_W, MIN_W);

  // Next state, counters and output values; outputs follow the next state so they are registered.
  always_comb begin
    est_d       = est_q;
    saque_cnt_d = saque_cnt_q;
    mov_cnt_d   = mov_cnt_q;
    pulso_d     = 1'b0;
    case (est_q)
      ST_OCIOSO: begin
        if (evento_iniciar) begin
          est_d       = ST_SAQUE;
          saque_cnt_d = '0;
        end
      end
      ST_SAQUE: begin
        if (saque_cnt_q >= SAQUE_MAX) begin
          est_d       = ST_JOGANDO;
          saque_cnt_d = '0;
          mov_cnt_d   = '0;
        end else begin
          saque_cnt_d = saque_cnt_q + 32'd1;
        end
      end
      ST_JOGANDO: begin
        // Leaving the state wins over a due pulse; the counter is left untouched.
        if (bola.ganhou) begin
          est_d = ST_GANHOU;
        end else if (bola.perdeu) begin
          est_d = ST_PERDEU;
        end else if (evento_pausa) begin
          est_d = ST_PAUSA;
        end else if (mov_cnt_q >= (periodo - 32'd1)) begin
          // >= rather than == so a period shortened mid-count fires immediately.
          pulso_d   = 1'b1;
          mov_cnt_d = '0;
        end else begin
          mov_cnt_d = mov_cnt_q + 32'd1;
        end
      end
      ST_PAUSA: begin
        if (evento_pausa) begin
          est_d = ST_JOGANDO;
        end
      end
      ST_PERDEU, ST_GANHOU: begin
        if (evento_iniciar) begin
          est_d       = ST_SAQUE;
          saque_cnt_d = '0;
        end
      end
      default: begin
        est_d = ST_OCIOSO;
      end
    endcase

    reset_bola_d = (est_d == ST_OCIOSO) || (est_d == ST_SAQUE);
    led_perdeu_d = (est_d == ST_PERDEU);
    led_ganhou_d = (est_d == ST_GANHOU);
  end

  // State, counters and registered outputs; reset drops any pending pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      est_q        <= ST_OCIOSO;
      saque_cnt_q  <= '0;
      mov_cnt_q    <= '0;
      pulso_q      <= 1'b0;
      reset_bola_q <= 1'b1;
      led_perdeu_q <= 1'b0;
      led_ganhou_q <= 1'b0;
    end else begin
      est_q        <= est_d;
      saque_cnt_q  <= saque_cnt_d;
      mov_cnt_q    <= mov_cnt_d;
      pulso_q      <= pulso_d;
      reset_bola_q <= reset_bola_d;
      led_perdeu_q <= led_perdeu_d;
      led_ganhou_q <= led_ganhou_d;
    end
  end

  assign estado                = est_q;
  assign led_perdeu            = led_perdeu_q;
  assign led_ganhou            = led_ganhou_q;
  assign bola.atualiza_posicao = pulso_q;
  assign bola.reset_bola       = reset_bola_q;

endmodule
